// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and opcode in, results and done pulse out.
// Master drives requests (in_valid, A, B, Cin, OP); slave answers with in_ready and the result fields.
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [3:0]       OP;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] C_hi;
    logic             Cout;
    logic             done;

    // A request is taken on a rising edge where in_valid and in_ready are both 1; nothing is queued while busy.
    modport master (
        output in_valid, A, B, Cin, OP,
        input  in_ready, C, C_hi, Cout, done
    );

    modport slave (
        input  in_valid, A, B, Cin, OP,
        output in_ready, C, C_hi, Cout, done
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops, bit-serial shifts, shift-add multiply.
// Results stay on C/C_hi/Cout until the next done pulse.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic       clk,
    input  logic       reset,
    seq_alu_if.slave   bus,
    output logic [1:0] dbg_state
);
    localparam int CW   = SHW + 1;
    localparam int HALF = WIDTH / 2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ID   = 4'd2;
    localparam logic [3:0] OP_NAND = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_XNOR = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_LRS  = 4'd10;
    localparam logic [3:0] OP_ARS  = 4'd11;
    localparam logic [3:0] OP_RR   = 4'd12;
    localparam logic [3:0] OP_LLS  = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;
    localparam logic [3:0] OP_LHI  = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d, c_hi_q, c_hi_d;
    logic             cout_q, cout_d, done_q, done_d;
    logic [WIDTH-1:0] work_q, work_d, acc_q, acc_d, mcand_q, mcand_d;
    logic [3:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic [CW-1:0]    amount;
    logic [WIDTH:0]   add_res, sub_res, mul_sum;
    logic [WIDTH-1:0] logic_res, shift_step, mul_lo;

    assign accept = bus.in_valid && (state_q == IDLE);
    assign amount = {1'b0, bus.B[SHW-1:0]};

    assign add_res = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.Cin};
    assign sub_res = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, bus.Cin};

    // Shift-add step: conditionally add the multiplicand, then shift {acc, work} right one bit.
    assign mul_sum = {1'b0, acc_q} + (work_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign mul_lo  = {mul_sum[0], work_q[WIDTH-1:1]};

    always_comb begin
        logic_res = '0;
        case (bus.OP)
            OP_ID:   logic_res = bus.A;
            OP_NAND: logic_res = ~(bus.A & bus.B);
            OP_NOR:  logic_res = ~(bus.A | bus.B);
            OP_XNOR: logic_res = ~(bus.A ^ bus.B);
            OP_NOT:  logic_res = ~bus.A;
            OP_AND:  logic_res = bus.A & bus.B;
            OP_OR:   logic_res = bus.A | bus.B;
            OP_XOR:  logic_res = bus.A ^ bus.B;
            OP_LHI:  logic_res = {bus.B[HALF-1:0], {HALF{1'b0}}};
            default: logic_res = '0;
        endcase
    end

    always_comb begin
        shift_step = work_q;
        case (op_q)
            OP_LRS:  shift_step = {1'b0, work_q[WIDTH-1:1]};
            OP_ARS:  shift_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            OP_RR:   shift_step = {work_q[0], work_q[WIDTH-1:1]};
            OP_LLS:  shift_step = {work_q[WIDTH-2:0], 1'b0};
            default: shift_step = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        c_hi_d  = c_hi_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        work_d  = work_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d = bus.OP;
                    case (bus.OP)
                        OP_ADD: begin
                            c_d    = add_res[WIDTH-1:0];
                            cout_d = add_res[WIDTH];
                            c_hi_d = '0;
                            done_d = 1'b1;
                        end
                        OP_SUB: begin
                            c_d    = sub_res[WIDTH-1:0];
                            cout_d = sub_res[WIDTH];
                            c_hi_d = '0;
                            done_d = 1'b1;
                        end
                        OP_LRS, OP_ARS, OP_RR, OP_LLS: begin
                            if (amount == '0) begin
                                c_d    = bus.A;
                                c_hi_d = '0;
                                cout_d = 1'b0;
                                done_d = 1'b1;
                            end else begin
                                work_d  = bus.A;
                                cnt_d   = amount;
                                state_d = SHIFT;
                            end
                        end
                        OP_MUL: begin
                            work_d  = bus.B;
                            mcand_d = bus.A;
                            acc_d   = '0;
                            cnt_d   = CW'(WIDTH);
                            state_d = MUL;
                        end
                        default: begin
                            c_d    = logic_res;
                            c_hi_d = '0;
                            cout_d = 1'b0;
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                work_d = shift_step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    c_d     = shift_step;
                    c_hi_d  = '0;
                    cout_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_d  = mul_sum[WIDTH:1];
                work_d = mul_lo;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    c_d     = mul_lo;
                    c_hi_d  = mul_sum[WIDTH:1];
                    cout_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            c_q     <= '0;
            c_hi_q  <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            work_q  <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            c_hi_q  <= c_hi_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
            work_q  <= work_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.C        = c_q;
    assign bus.C_hi     = c_hi_q;
    assign bus.Cout     = cout_q;
    assign bus.done     = done_q;
    assign dbg_state    = state_q;
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; SHALL be an even value of at least 4.
REQ-002 Parameter SHW, default 4, shift-amount width; SHALL equal ceil(log2(WIDTH)).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B; B[SHW-1:0] is the shift amount for shift ops.
REQ-009 Cin  input  1  carry/borrow in for ADD and SUB.
REQ-010 OP  input  4  operation code.
REQ-011 C  output  WIDTH  result, or low half of the product for MUL.
REQ-012 C_hi  output  WIDTH  high half of the product for MUL; 0 for all other ops.
REQ-013 Cout  output  1  carry out for ADD and SUB; 0 for all other ops.
REQ-014 done  output  1  one-cycle pulse when C, C_hi and Cout are valid.

Function
REQ-015 Accept SHALL occur on an edge where in_valid=1 and in_ready=1; A, B, Cin and OP SHALL be captured at that edge.
REQ-016 in_ready SHALL be 1 exactly when the FSM is in IDLE; in_valid while busy SHALL be ignored, with no queuing.
REQ-017 FSM states SHALL be IDLE, SHIFT and MUL.
- IDLE -> SHIFT on accept of a shift op with amount >= 1.
- IDLE -> MUL on accept of MUL.
- All other accepts SHALL stay in IDLE.
REQ-018 Op codes and results (W = WIDTH):
- Arithmetic: 0 ADD {Cout,C}=A+B+Cin; 1 SUB {Cout,C}=A-B-Cin (modulo 2^(W+1), Cout=borrow bit).
- Logic: 2 ID C=A; 3 NAND; 4 NOR; 5 XNOR; 6 NOT C=~A; 7 AND; 8 OR; 9 XOR.
- Shifts: 10 LRS logical right; 11 ARS arithmetic right (sign fill); 12 RR rotate right; 13 LLS logical left.
- 14 MUL: unsigned {C_hi,C}=A*B.
- 15 LHI: C={B[W/2-1:0], W/2 zeros}.
REQ-019 Single-cycle ops (0-9, 15, and shifts with amount 0) SHALL register the result at the accept edge and assert done in the next cycle; latency 1.
REQ-020 A shift with amount 0 SHALL return C=A.
REQ-021 A shift with amount n >= 1 SHALL move exactly one bit position per cycle in SHIFT and assert done n cycles after accept.
REQ-022 MUL SHALL use shift-add, one multiplier bit per cycle, and assert done exactly WIDTH cycles after accept.
REQ-023 The FSM SHALL return to IDLE in the same cycle done is asserted, so in_ready=1 during done and back-to-back accepts are legal.
REQ-024 C, C_hi and Cout SHALL hold their last completed values until the next done.
- Intermediate values during SHIFT and MUL SHALL be held in internal registers, not driven on C or C_hi.
REQ-025 done SHALL never be high for two consecutive cycles from a single accept.
REQ-026 Arithmetic SHALL be unsigned except ARS; no overflow flag is produced.

Reset
REQ-027 While reset=1, the block SHALL immediately force:
- state=IDLE, in_ready=1, done=0;
- C=0, C_hi=0, Cout=0;
- all internal counters and operand registers to 0.
REQ-028 Reset asserted mid-SHIFT or mid-MUL SHALL abort the operation with no done pulse.
- After release, the first accept SHALL behave as if from power-up.
REQ-029 An accept SHALL NOT occur on an edge where reset=1.

Verification (WIDTH=16)
REQ-030 ADD A=FFFF B=0001 Cin=1 -> done after 1 cycle, C=0001, Cout=1, C_hi=0.
REQ-031 ARS A=8010 amount=4 -> in_ready=0 for 4 cycles, done 4 cycles after accept, C=F801.
- Same sequence with RR A=0001 amount=1 -> C=8000.
REQ-032 MUL A=FFFF B=FFFF -> done exactly 16 cycles after accept, C_hi=FFFE, C=0001.
- in_valid pulses during busy SHALL be ignored.
REQ-033 Back-to-back: LHI B=00AB accepted in the done cycle of a prior XOR -> next cycle C=AB00, Cout=0.
REQ-034 Reset asserted 5 cycles into MUL -> outputs 0 immediately, no done pulse.
- Then SUB A=0000 B=0001 Cin=0 -> C=FFFF, Cout=1.
